// File: rtl/cla_pkg.sv
// Shared types for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/gp_group.sv
// One carry-lookahead block: generate/propagate, ripple chain inside the block,
// plus block-level G and P for carry-out prediction.
module gp_group #(
  parameter int unsigned GROUP = 8
) (
  input  logic [GROUP-1:0] i_a,
  input  logic [GROUP-1:0] i_b,
  input  logic             i_cin,
  output logic [GROUP-1:0] o_sum,
  output logic             o_cout,
  output logic             o_g,
  output logic             o_p
);

  logic [GROUP-1:0] w_g;
  logic [GROUP-1:0] w_p;
  logic [GROUP:0]   w_c;
  // Same chain with carry-in forced to 0 gives the block generate term.
  logic [GROUP:0]   w_gc;

  assign w_g = i_a & i_b;
  assign w_p = i_a | i_b;

  always_comb begin
    w_c     = '0;
    w_gc    = '0;
    w_c[0]  = i_cin;
    w_gc[0] = 1'b0;
    for (int i = 0; i < int'(GROUP); i++) begin
      w_c[i+1]  = w_g[i] | (w_p[i] & w_c[i]);
      w_gc[i+1] = w_g[i] | (w_p[i] & w_gc[i]);
    end
  end

  assign o_sum  = i_a ^ i_b ^ w_c[GROUP-1:0];
  assign o_cout = w_c[GROUP];
  assign o_g    = w_gc[GROUP];
  assign o_p    = &w_p;

endmodule

// File: rtl/cla_pipe.sv
// Pipelined CLA adder/subtractor: one GROUP-bit block resolves per stage, with an
// elastic valid/ready chain so any stage can stall independently.
module cla_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned STAGES = WIDTH / GROUP;
  localparam int unsigned MSB    = WIDTH - 1;

  if (WIDTH % GROUP != 0) begin : g_bad_width
    $error("cla_pipe: WIDTH must be a multiple of GROUP");
  end

  // b holds b_eff (already inverted for SUB); c is the carry into the next block.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
  } payload_t;

  payload_t            r_pl  [STAGES];
  payload_t            w_nxt [STAGES];
  logic [STAGES-1:0]   r_valid;
  logic [STAGES-1:0]   w_up_valid;
  logic [STAGES:0]     w_ready;

  always_comb begin
    w_ready         = '0;
    w_ready[STAGES] = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      w_ready[k] = ~r_valid[k] | w_ready[k+1];
    end
  end

  assign in_ready = w_ready[0] & ~flush;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    payload_t         w_src;
    payload_t         w_stg;
    logic [GROUP-1:0] w_gsum;
    logic             w_gcout;
    logic             w_gg;
    logic             w_gp;

    if (k == 0) begin : g_head
      always_comb begin
        w_src.a = a;
        w_src.b = (op == OP_SUB) ? ~b : b;
        w_src.s = '0;
        w_src.c = (op == OP_SUB) ? 1'b1 : cin;
      end
      assign w_up_valid[k] = in_valid & in_ready;
    end else begin : g_body
      assign w_src         = r_pl[k-1];
      assign w_up_valid[k] = r_valid[k-1];
    end

    gp_group #(
      .GROUP(GROUP)
    ) u_gp (
      .i_a   (w_src.a[k*GROUP +: GROUP]),
      .i_b   (w_src.b[k*GROUP +: GROUP]),
      .i_cin (w_src.c),
      .o_sum (w_gsum),
      .o_cout(w_gcout),
      .o_g   (w_gg),
      .o_p   (w_gp)
    );

    // Rippled and lookahead carry-out of the block must always agree.
    always_comb begin
      a_carry_consistent : assert (w_gcout == (w_gg | (w_gp & w_src.c)));
    end

    always_comb begin
      w_stg                     = w_src;
      w_stg.s[k*GROUP +: GROUP] = w_gsum;
      w_stg.c                   = w_gcout;
    end

    assign w_nxt[k] = w_stg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        r_pl[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (flush) begin
          r_valid[k] <= 1'b0;
        end else if (w_ready[k]) begin
          r_valid[k] <= w_up_valid[k];
        end
        // Load only real transfers so a stalled or idle stage stays bit-stable.
        if (w_ready[k] && w_up_valid[k]) begin
          r_pl[k] <= w_nxt[k];
        end
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign sum       = r_pl[STAGES-1].s;
  assign cout      = r_pl[STAGES-1].c;
  assign ovf       = (r_pl[STAGES-1].a[MSB] == r_pl[STAGES-1].b[MSB]) &
                     (r_pl[STAGES-1].s[MSB] != r_pl[STAGES-1].a[MSB]);
  assign zero      = (r_pl[STAGES-1].s == '0);

endmodule
